// File: rtl/bus_pwm.sv
// bus_pwm: memory-mapped single-channel PWM generator with double-buffered PERIOD/DUTY on a shared tristate bus.
// Latency: register writes take effect the next cycle; pwm_out is registered one cycle behind the period counter.
// Backpressure: none, every bus access completes in one cycle; optional macro PWM_IRQ_EN enables int_pwm and CTRL.irq_en.
module bus_pwm #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              EN,
  input  logic [ADDR_W-1:0] addr,
  input  logic              ctrl,
  inout  wire  [DATA_W-1:0] data,
  output logic              pwm_out,
  output logic              int_pwm
);

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_PRESC  = 4'h1;
  localparam logic [3:0] OFF_PERIOD = 4'h2;
  localparam logic [3:0] OFF_DUTY   = 4'h3;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_COUNT  = 4'h5;

  logic [3:0]        reg_off;
  logic              bus_wr;
  logic              bus_rd;
  logic [DATA_W-1:0] rd_dat;

  // software-visible registers
  logic              enable;
  logic              polarity;
  logic              irq_en;
  logic [DATA_W-1:0] prescale;
  logic [DATA_W-1:0] period;
  logic [DATA_W-1:0] duty;
  logic              flag;

  // running state
  logic [DATA_W-1:0] pre_cnt;
  logic [DATA_W-1:0] cnt;
  logic [DATA_W-1:0] period_act;
  logic [DATA_W-1:0] duty_act;
  logic              tick;
  logic              wrap;

  // only the low nibble is decoded; the decoder already qualified the upper bits via EN
  logic unused_addr;
  assign unused_addr = ^addr[ADDR_W-1:4];

  assign reg_off = addr[3:0];
  assign bus_wr  = EN & ctrl;
  assign bus_rd  = EN & ~ctrl;

  assign tick = enable && (pre_cnt == prescale);
  assign wrap = tick && (cnt == period_act);

  // register file writes; CTRL.irq_en only exists when the interrupt option is built in
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enable   <= 1'b0;
      polarity <= 1'b0;
      prescale <= '0;
      period   <= '0;
      duty     <= '0;
    end else if (bus_wr) begin
      case (reg_off)
        OFF_CTRL: begin
          enable   <= data[0];
          polarity <= data[1];
        end
        OFF_PRESC:  prescale <= data;
        OFF_PERIOD: period   <= data;
        OFF_DUTY:   duty     <= data;
        default: ;
      endcase
    end
  end

`ifdef PWM_IRQ_EN
  // interrupt enable bit and registered level interrupt
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_en  <= 1'b0;
      int_pwm <= 1'b0;
    end else begin
      if (bus_wr && reg_off == OFF_CTRL) begin
        irq_en <= data[2];
      end
      int_pwm <= flag & irq_en;
    end
  end
`else
  assign irq_en  = 1'b0;
  assign int_pwm = 1'b0;
`endif

  // prescaler and period counter; shadows are copied into the active set at wrap or while stopped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt    <= '0;
      cnt        <= '0;
      period_act <= '0;
      duty_act   <= '0;
    end else if (!enable) begin
      pre_cnt    <= '0;
      cnt        <= '0;
      period_act <= period;
      duty_act   <= duty;
    end else if (tick) begin
      pre_cnt <= '0;
      if (cnt == period_act) begin
        cnt        <= '0;
        period_act <= period;
        duty_act   <= duty;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // wrap flag: a wrap in the same cycle as a software clear keeps the flag set
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag <= 1'b0;
    end else if (wrap) begin
      flag <= 1'b1;
    end else if (bus_wr && reg_off == OFF_STATUS && data[0]) begin
      flag <= 1'b0;
    end
  end

  // registered waveform; idles at the inactive level (the polarity bit) when stopped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_out <= 1'b0;
    end else if (enable) begin
      pwm_out <= (cnt < duty_act) ^ polarity;
    end else begin
      pwm_out <= polarity;
    end
  end

  // read mux for the addressed register; unmapped offsets read zero
  always_comb begin
    rd_dat = '0;
    case (reg_off)
      OFF_CTRL: begin
        rd_dat[0] = enable;
        rd_dat[1] = polarity;
        rd_dat[2] = irq_en;
      end
      OFF_PRESC:  rd_dat = prescale;
      OFF_PERIOD: rd_dat = period;
      OFF_DUTY:   rd_dat = duty;
      OFF_STATUS: rd_dat[0] = flag;
      OFF_COUNT:  rd_dat = cnt;
      default:    rd_dat = '0;
    endcase
  end

  // the bus is only driven during a selected read outside reset
  assign data = (rst_n && bus_rd) ? rd_dat : {DATA_W{1'bz}};

endmodule

// File: tb/tb_bus_pwm.sv
// tb_bus_pwm: randomized and directed stimulus for bus_pwm against a period-level reference model.
// Latency: outputs compared 1 time unit after every rising edge, bus reads 1 time unit after the inputs settle.
// Backpressure: n/a; the bench drives the shared bus only for writes and isolation probes.
`timescale 1ns/1ps
module tb_bus_pwm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_en = 1'b0;
  logic        ctrl = 1'b0;
  logic [15:0] addr = '0;
  logic        drv = 1'b0;
  logic [15:0] drv_dat = '0;
  wire  [15:0] data;
  logic        pwm_out;
  logic        int_pwm;

  int checks = 0;
  int errors = 0;

`ifdef PWM_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  // reference model: the period is viewed as (period+1)*(prescale+1) clock slots,
  // the counter value is simply slot/(prescale+1)
  bit     m_en, m_pol, m_irq, m_flag, m_pwm, m_int;
  longint m_pre, m_per, m_duty, m_pos, m_pa, m_da;

  assign data = drv ? drv_dat : 16'hzzzz;

  bus_pwm #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .EN(bus_en), .addr(addr), .ctrl(ctrl),
    .data(data), .pwm_out(pwm_out), .int_pwm(int_pwm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_pol = 0; m_irq = 0; m_flag = 0; m_pwm = 0; m_int = 0;
    m_pre = 0; m_per = 0; m_duty = 0; m_pos = 0; m_pa = 0; m_da = 0;
  endtask

  function automatic logic [15:0] model_read(input logic [3:0] off);
    case (off)
      4'h0: return {13'b0, m_irq, m_pol, m_en};
      4'h1: return 16'(m_pre);
      4'h2: return 16'(m_per);
      4'h3: return 16'(m_duty);
      4'h4: return {15'b0, m_flag};
      4'h5: return 16'(m_pos / (m_pre + 1));
      default: return 16'h0000;
    endcase
  endfunction

  // advance the model by one clock edge; writes land after the edge's own computation
  task automatic model_step(input bit wr, input logic [3:0] off, input logic [15:0] d);
    bit n_pwm, n_int, wrapped;
    wrapped = 0;
    n_pwm = m_en ? ((((m_pos / (m_pre + 1)) < m_da) ? 1'b1 : 1'b0) ^ m_pol) : m_pol;
    n_int = IRQ ? (m_flag & m_irq) : 1'b0;
    if (m_en) begin
      m_pos++;
      if (m_pos == (m_pa + 1) * (m_pre + 1)) begin
        wrapped = 1; m_pos = 0; m_pa = m_per; m_da = m_duty;
      end
    end else begin
      m_pos = 0; m_pa = m_per; m_da = m_duty;
    end
    if (wrapped) m_flag = 1;
    else if (wr && off == 4'h4 && d[0]) m_flag = 0;
    if (wr) begin
      case (off)
        4'h0: begin m_en = d[0]; m_pol = d[1]; m_irq = IRQ ? d[2] : 1'b0; end
        4'h1: m_pre = longint'(d);
        4'h2: m_per = longint'(d);
        4'h3: m_duty = longint'(d);
        default: ;
      endcase
    end
    m_pwm = n_pwm;
    m_int = n_int;
  endtask

  // one bus cycle: drive, optionally check a read, clock, then compare outputs
  task automatic cycle(input bit en_i, input bit wr_i, input logic [3:0] off,
                       input logic [15:0] wd, input bit rd_chk);
    bus_en = en_i; ctrl = wr_i; addr = {12'($urandom), off};
    drv = wr_i; drv_dat = wd;
    #1;
    if (wr_i) check("wr_bus_free", data, wd);
    if (rd_chk && en_i && !wr_i) check("rd_reg", data, model_read(off));
    @(posedge clk);
    model_step(en_i && wr_i, off, wd);
    #1;
    check("pwm_out", pwm_out, m_pwm);
    check("int_pwm", int_pwm, m_int);
  endtask

  task automatic wr(input logic [3:0] off, input logic [15:0] d); cycle(1, 1, off, d, 0); endtask
  task automatic rd(input logic [3:0] off); cycle(1, 0, off, 16'h0, 1); endtask
  task automatic idle(input int n); repeat (n) cycle(0, 0, 4'h0, 16'h0, 0); endtask

  // combinational read without consuming a clock edge
  task automatic peek(input logic [3:0] off, output logic [15:0] v);
    bus_en = 1; ctrl = 0; drv = 0; addr = {12'hFF6, off};
    #1;
    v = data;
  endtask

  // with EN low the bench pulls the bus to 0; any drive from the block would corrupt it
  task automatic iso(input logic [3:0] off, input logic ctl);
    bus_en = 0; ctrl = ctl; addr = {12'hFF6, off}; drv = 1; drv_dat = 16'h0000;
    #1;
    check("iso_bus", data, 16'h0000);
    drv = 0;
  endtask

  // length of the next complete run of pwm_out at level lv
  task automatic run_len(input string tag, input logic lv, input int expv);
    int n, lim;
    n = 0; lim = 0;
    while (pwm_out === lv && lim < 60) begin idle(1); lim++; end
    while (pwm_out !== lv && lim < 60) begin idle(1); lim++; end
    while (pwm_out === lv && lim < 60) begin idle(1); n++; lim++; end
    check(tag, n, expv);
  endtask

  initial begin
    logic [15:0] v;
    int n;
    model_reset();

    // reset
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_pwm", pwm_out, 1'b0);
    check("rst_int", int_pwm, 1'b0);
    iso(4'h0, 1'b0);
    for (int i = 0; i < 6; i++) rd(4'(i));

    // basic waveform: 3 high, 7 low
    wr(4'h1, 16'd0); wr(4'h2, 16'd9); wr(4'h3, 16'd3); wr(4'h0, 16'h1);
    run_len("basic_high", 1'b1, 3);
    run_len("basic_low", 1'b0, 7);
    peek(4'h4, v);
    check("basic_flag", v, 16'h1);
    wr(4'h4, 16'h1);

    // prescale 1, active-low: period 10 with 4 low, 6 high
    wr(4'h0, 16'h0); wr(4'h1, 16'd1); wr(4'h2, 16'd4); wr(4'h3, 16'd2); wr(4'h0, 16'h3);
    run_len("pol_low", 1'b0, 4);
    run_len("pol_high", 1'b1, 6);
    wr(4'h0, 16'h2);
    idle(2);
    n = 0;
    for (int i = 0; i < 10; i++) begin idle(1); if (pwm_out === 1'b1) n++; end
    check("disabled_level", n, 10);

    // shadow update mid-period
    wr(4'h0, 16'h0); wr(4'h1, 16'd0); wr(4'h2, 16'd9); wr(4'h3, 16'd3); wr(4'h0, 16'h1);
    n = 0;
    while (m_pos != 5 && n < 40) begin idle(1); n++; end
    rd(4'h5);
    wr(4'h3, 16'd8);
    run_len("shadow_high", 1'b1, 8);
    wr(4'h3, 16'd0);
    idle(20);
    n = 0;
    for (int i = 0; i < 10; i++) begin idle(1); if (pwm_out === 1'b1) n++; end
    check("duty0_level", n, 0);
    wr(4'h3, 16'd20);
    idle(20);
    n = 0;
    for (int i = 0; i < 10; i++) begin idle(1); if (pwm_out === 1'b1) n++; end
    check("duty20_level", n, 10);

    // interrupt behaviour
    wr(4'h0, 16'h0); wr(4'h2, 16'd3); wr(4'h3, 16'd1); wr(4'h4, 16'h1);
    idle(2);
    wr(4'h0, 16'h5);
`ifdef PWM_IRQ_EN
    n = 0;
    while (int_pwm !== 1'b1 && n < 20) begin idle(1); n++; end
    check("irq_rise_delay", n, 5);
    wr(4'h4, 16'h1);
    idle(1);
    check("irq_cleared", int_pwm, 1'b0);
`else
    peek(4'h0, v);
    check("irq_bit_absent", v, 16'h1);
    idle(12);
    check("irq_tied_low", int_pwm, 1'b0);
`endif
    n = 0;
    while (m_pos != 3 && n < 20) begin idle(1); n++; end
    wr(4'h4, 16'h1);
    peek(4'h4, v);
    check("clear_vs_wrap", v, 16'h1);

    // bus isolation
    cycle(0, 1, 4'h2, 16'hFFFF, 0);
    peek(4'h2, v);
    check("iso_period_kept", v, 16'd3);
    iso(4'h2, 1'b0);
    iso(4'h2, 1'b1);

    // randomized configurations with background bus traffic
    for (int it = 0; it < 25; it++) begin
      logic [15:0] dv;
      wr(4'h0, 16'h0);
      wr(4'h1, 16'($urandom_range(0, 3)));
      wr(4'h2, 16'($urandom_range(0, 12)));
      case ($urandom_range(0, 7))
        0: dv = 16'hFFFF;
        1: dv = 16'h8000;
        default: dv = 16'($urandom_range(0, 15));
      endcase
      wr(4'h3, dv);
      wr(4'h0, {13'b0, 1'($urandom), 1'($urandom), 1'b1});
      for (int c = 0; c < 40; c++) begin
        int r;
        logic [3:0] off;
        r = $urandom_range(0, 9);
        off = 4'($urandom_range(0, 15));
        if (r == 0) begin
          // prescale stays fixed while running so the slot model holds
          if (off == 4'h1) off = 4'h3;
          if (off == 4'h0) wr(off, {13'b0, 3'($urandom)});
          else wr(off, 16'($urandom_range(0, 15)));
        end else if (r < 4) begin
          rd(off);
        end else begin
          idle(1);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_pwm.md
Name: bus_pwm

Overview:
- Memory-mapped PWM generator that sits on the peripheral bus directly downstream of the bus address decoder, in the free peripheral slot at 0xFF60–0xFF6F.
- It is selected by the decoder's one-hot bus-consent bit (EN).
- The CPU reads and writes its registers over the shared tristate data bus.
- Produces one PWM waveform and a level interrupt on period wrap.

Parameters:
- ADDR_W, 16, bus address width; only addr[3:0] is decoded.
- DATA_W, 16, data bus width and width of all counters and registers.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst_n  input  1  synchronous active-low reset.
- EN  input  1  bus consent from decoder; block is selected when high.
- addr  input  ADDR_W  bus address; register offset = addr[3:0].
- ctrl  input  1  1 = write, 0 = read.
- data  inout  DATA_W  shared data bus; driven only during a selected read, otherwise high-Z.
- pwm_out  output  1  registered PWM waveform.
- int_pwm  output  1  level interrupt (see Optional Feature).

Behaviour:
- Register map (offset: contents):
  - 0x0 CTRL: bit0 enable, bit1 polarity (1 = active-low), bit2 irq_en. Other bits read 0.
  - 0x1 PRESCALE: full width.
  - 0x2 PERIOD: shadow, full width.
  - 0x3 DUTY: shadow, full width.
  - 0x4 STATUS: bit0 wrap flag. Writing 1 to bit0 clears the flag; writing 0 has no effect.
  - 0x5 COUNT: read-only, current cnt.
  - 0x6–0xF: read 0, writes ignored.
- Write: on rising clk when EN && ctrl && rst_n, the addressed register takes data. Takes effect the next cycle.
- Read: when EN && !ctrl, data is combinationally driven with the addressed register value. Otherwise data = 'z.
- Reset (rst_n low at clk edge):
  - All registers, pre_cnt, cnt, period_act, duty_act and flag clear to 0.
  - pwm_out = 0 and int_pwm = 0.
  - data is released to high-Z.
  - Reset mid-period aborts immediately with no wrap event.
- Prescaler:
  - While enable = 1, pre_cnt counts 0..PRESCALE.
  - tick = (pre_cnt == PRESCALE); pre_cnt returns to 0 on tick.
  - PRESCALE = 0 gives tick every cycle.
- Period counter, on tick:
  - If cnt == period_act: cnt <= 0, period_act <= PERIOD, duty_act <= DUTY, flag <= 1.
  - Else cnt <= cnt + 1.
  - Period length = (period_act + 1) × (PRESCALE + 1) clk cycles.
- Double buffering:
  - PERIOD/DUTY writes while running take effect only at the next wrap. No glitch or truncated period.
- Disabled (enable = 0):
  - pre_cnt = cnt = 0.
  - period_act/duty_act load from PERIOD/DUTY every cycle, so the first period after enable uses the current shadows.
  - flag holds its value.
- Output:
  - pwm_out <= enable ? ((cnt < duty_act) ^ polarity) : polarity.
  - One-cycle registered latency from cnt.
  - DUTY = 0 gives constant inactive.
  - DUTY > period_act gives constant active.
  - Compare is unsigned, full width.
- Simultaneous STATUS clear write and wrap in the same cycle: set wins, flag = 1.
- Simultaneous PRESCALE write and tick: the tick in progress completes with the old value; the new value is used from the next cycle.
- Counter wrap at 0xFFFF PERIOD behaves normally (cnt never exceeds period_act).

Optional Feature:
- Macro: PWM_IRQ_EN.
- Defined: int_pwm <= flag & irq_en (registered, one cycle after the flag sets). It stays high until software clears the flag or clears irq_en.
- Undefined: int_pwm is tied to 0 and CTRL bit2 reads 0 and ignores writes. STATUS flag still sets and clears and is pollable.

Test Plan:
- Reset:
  - Stimulus: hold rst_n = 0 for 2 cycles, then read offsets 0x0–0x5.
  - Required: all read 0, pwm_out = 0, int_pwm = 0, data = 'z when EN = 0.
- Basic waveform:
  - Stimulus: PRESCALE = 0, PERIOD = 9, DUTY = 3, CTRL = 0x1.
  - Required: pwm_out high 3 cycles, low 7 cycles, period 10 cycles, flag set every 10 cycles.
- Prescale and polarity:
  - Stimulus: PRESCALE = 1, PERIOD = 4, DUTY = 2, CTRL = 0x3.
  - Required: period 10 cycles, pwm_out low 4 cycles, high 6 cycles. CTRL = 0x2 (disabled) gives pwm_out constant 1.
- Shadow update:
  - Stimulus: running PERIOD = 9, DUTY = 3; write DUTY = 8 at cnt = 5.
  - Required: the current period keeps 3-cycle active; the next period shows 8-cycle active. DUTY = 0 gives constant 0; DUTY = 20 gives constant 1.
- Interrupt with PWM_IRQ_EN defined:
  - Stimulus: CTRL = 0x5, PERIOD = 3, DUTY = 1.
  - Required: int_pwm rises 1 cycle after the first wrap. Writing STATUS = 1 drops it. A STATUS = 1 write on the exact wrap cycle leaves the flag = 1.
- Bus isolation:
  - Stimulus: EN = 0 with ctrl = 1 writing 0xFFFF to offset 0x2.
  - Required: PERIOD is unchanged, and data is never driven by the block while EN = 0 or ctrl = 1.
